// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS main control unit:
// opcodes, ALUOp codes and the FSM state encoding.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12,
        S_HALT   = 4'd15
    } state_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: legal = 1'b1;
            default:                                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch/decode/execute/
// memory/writeback; datapath controls are decoded from the state register.
module mc_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    state_t r_state;

    // State register and next-state selection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
        end else begin
            case (r_state)
                S_INIT:   r_state <= S_FETCH;
                S_FETCH:  begin
                    if (mem_ready) r_state <= S_DECODE;
                    else           r_state <= S_FETCH;
                end
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE:     r_state <= S_EXEC;
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_J:         r_state <= S_JUMP;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        default: begin
                            if (HALT_ON_ILLEGAL) r_state <= S_HALT;
                            else                 r_state <= S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    if (opcode == OP_LW) r_state <= S_MEMRD;
                    else                 r_state <= S_MEMWR;
                end
                S_MEMRD:  begin
                    if (mem_ready) r_state <= S_MEMWB;
                    else           r_state <= S_MEMRD;
                end
                S_MEMWB:  r_state <= S_FETCH;
                S_MEMWR:  begin
                    if (mem_ready) r_state <= S_FETCH;
                    else           r_state <= S_MEMWR;
                end
                S_EXEC:   r_state <= S_ALUWB;
                S_ALUWB:  r_state <= S_FETCH;
                S_BRANCH: r_state <= S_FETCH;
                S_JUMP:   r_state <= S_FETCH;
                S_ADDIEX: r_state <= S_ADDIWB;
                S_ADDIWB: r_state <= S_FETCH;
                S_HALT:   r_state <= S_HALT;
                default:  r_state <= S_INIT;
            endcase
        end
    end

    // Output decode; only fetch handshake, branch zero and decode legality look past the state
    always_comb begin
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALUOP_ADD;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        illegal_op = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                illegal_op = ~is_legal_op(opcode);
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = 2'b01;
                pc_en     = zero;
            end
            S_JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            default: begin
                iord = 1'b0;
            end
        endcase
    end

    assign state_dbg = r_state;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle MIPS main control unit. Sequences each instruction through fetch, decode, execute, memory and writeback states, and drives datapath enables plus the 2-bit ALUOp consumed by the downstream ALU control stage.
- Sits between the instruction register opcode field and the datapath muxes/enables.
- Supports R-type, lw, sw, beq, j and addi, with a memory-ready handshake on every memory access.

Parameters:
- HALT_ON_ILLEGAL, 0, 0: an illegal opcode pulses illegal_op and returns to S_FETCH; 1: enters S_HALT until reset.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current read/write this cycle
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load enable
- reg_dst  out  1  register write address select: 0 = rt, 1 = rd
- mem_to_reg  out  1  register write data select: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = immediate shifted left 2
- alu_op  out  2  00 = add, 01 = subtract, 10 = decode by funct
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- pc_en  out  1  PC load enable
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state_dbg  out  4  current state encoding

Behaviour:
- Moore FSM with a 4-bit registered state. All outputs are decoded combinationally from the state; only the listed outputs are qualified by mem_ready or zero. Every output not listed for a state is 0.
- Reset: rst_n low forces S_INIT asynchronously. S_INIT drives every output to 0 and state_dbg = 0. The first rising edge after rst_n goes high moves to S_FETCH. Reset mid-instruction abandons the instruction; no partial writes occur after the reset edge.
- S_FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_en are asserted only when mem_ready=1.
  - Stay in S_FETCH while mem_ready=0; move to S_DECODE when mem_ready=1.
- S_DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Branch by opcode:
  - 000000 -> S_EXEC
  - 100011 or 101011 -> S_MEMADR
  - 000100 -> S_BRANCH
  - 000010 -> S_JUMP
  - 001000 -> S_ADDIEX
  - any other opcode -> illegal_op=1 this cycle, then S_FETCH (HALT_ON_ILLEGAL=0) or S_HALT (HALT_ON_ILLEGAL=1)
- S_MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is S_MEMRD for lw, S_MEMWR for sw. Opcode is stable from the IR.
- S_MEMRD: iord=1, mem_read=1. Wait while mem_ready=0; then S_MEMWB.
- S_MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next S_FETCH.
- S_MEMWR: iord=1, mem_write=1. Wait while mem_ready=0; then S_FETCH.
- S_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next S_ALUWB.
- S_ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Next S_FETCH.
- S_BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero. Next S_FETCH.
- S_JUMP: pc_src=10, pc_en=1. Next S_FETCH.
- S_ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next S_ADDIWB.
- S_ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Next S_FETCH.
- S_HALT: all outputs 0. Exit only through reset.
- Latency with mem_ready always 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles. Each mem_ready=0 cycle in S_FETCH, S_MEMRD or S_MEMWR adds exactly one cycle.
- mem_read and mem_write are never asserted in the same cycle. reg_write and pc_en are never asserted together.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ALUOp constants ALUOP_ADD = 00, ALUOP_SUB = 01, ALUOP_FUNCT = 10
  - state encodings S_INIT = 0, S_FETCH = 1 through S_ADDIWB = 12, S_HALT = 15
- No sub-module. Next-state logic and output decode stay as two processes in the one module.

Test Plan:
- Reset: rst_n held low for 3 cycles, then released -> all outputs 0 during reset; S_INIT then S_FETCH on the next edge; state_dbg goes 0 -> 1.
- R-type: opcode=000000, mem_ready=1 -> 4 cycles; alu_op=10 in S_EXEC; reg_write=1 with reg_dst=1 in the 4th cycle; pc_en=1 only in the 1st cycle.
- lw with mem_ready low for 2 cycles in S_MEMRD: opcode=100011 -> 7 cycles total; iord=1 and mem_read=1 for 3 consecutive cycles; then reg_write=1 with mem_to_reg=1.
- beq: opcode=000100 run once with zero=1 and once with zero=0 -> alu_op=01 and pc_src=01 in the 3rd cycle; pc_en=1 when zero=1, pc_en=0 when zero=0.
- Illegal opcode: opcode=111111 -> illegal_op pulses for exactly one cycle in S_DECODE; then S_FETCH with HALT_ON_ILLEGAL=0, or state_dbg stuck at 15 with HALT_ON_ILLEGAL=1 until rst_n is pulsed.
- Reset mid-instruction: rst_n dropped during S_MEMWR of a sw -> mem_write goes 0 asynchronously, before the next clock edge; after release the FSM restarts at S_INIT.
